// File: rtl/uart_led_cmd.sv
// LF-terminated ASCII LED command parser between the UART RX FIFO and UART TX.
// "Lhh" sets the LED register, "R" reads it back as hex; bad lines get "?".
module uart_led_cmd #(
  parameter int unsigned          LED_WIDTH = 8,
  parameter logic [LED_WIDTH-1:0] LED_RESET = '0
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 i_Received,
  output logic                 o_Read_FIFO,
  input  logic                 i_Data_Ready,
  input  logic [7:0]           i_Data,
  output logic                 o_Start,
  output logic [7:0]           o_TX_Data,
  input  logic                 i_Busy_TX,
  output logic [LED_WIDTH-1:0] o_LED,
  output logic                 o_Cmd_Error
);

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_K  = 8'h4B;
  localparam logic [7:0] CH_Q  = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_PARSE,
    S_TX_START,
    S_TX_BUSY,
    S_TX_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] rx_byte;
  logic [7:0] line_cmd, line_arg0, line_arg1;
  logic [1:0] line_cnt;
  logic       line_err;
  logic [7:0] tx_q1, tx_q2;
  logic [1:0] tx_left;
  logic [7:0] led8;
  logic       line_empty, cmd_set, cmd_read;

  function automatic logic is_hex(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
           (c >= 8'h61 && c <= 8'h66);
  endfunction

  function automatic logic [3:0] hex_val(input logic [7:0] c);
    logic [7:0] v;
    if (c <= 8'h39)      v = c - 8'h30;
    else if (c <= 8'h46) v = c - 8'h37;
    else                 v = c - 8'h57;
    return v[3:0];
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    led8       = 8'(o_LED);
    line_empty = (line_cnt == 2'd0) && !line_err;
    cmd_set    = !line_err && (line_cnt == 2'd3) && (line_cmd == CH_L) &&
                 is_hex(line_arg0) && is_hex(line_arg1);
    cmd_read   = !line_err && (line_cnt == 2'd1) && (line_cmd == CH_R);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    o_Start = 1'b0;
    unique case (state_q)
      S_IDLE:      if (i_Received) state_d = S_WAIT_DATA;
      S_WAIT_DATA: if (i_Data_Ready) state_d = S_PARSE;
      S_PARSE:     state_d = (rx_byte == CH_LF && !line_empty) ? S_TX_START : S_IDLE;
      S_TX_START: begin
        if (!i_Busy_TX) begin
          o_Start = 1'b1;
          state_d = S_TX_BUSY;
        end
      end
      S_TX_BUSY:   if (i_Busy_TX) state_d = S_TX_BUSY == S_TX_BUSY ? S_TX_DONE : S_TX_BUSY;
      S_TX_DONE:   if (!i_Busy_TX) state_d = (tx_left != 2'd0) ? S_TX_START : S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      o_Read_FIFO <= 1'b0;
      o_Cmd_Error <= 1'b0;
      o_TX_Data   <= '0;
      o_LED       <= LED_RESET;
      rx_byte     <= '0;
      line_cmd    <= '0;
      line_arg0   <= '0;
      line_arg1   <= '0;
      line_cnt    <= '0;
      line_err    <= 1'b0;
      tx_q1       <= '0;
      tx_q2       <= '0;
      tx_left     <= '0;
    end else begin
      o_Read_FIFO <= (state_q == S_IDLE) && i_Received;
      o_Cmd_Error <= 1'b0;
      if (state_q == S_WAIT_DATA && i_Data_Ready) rx_byte <= i_Data;
      if (state_q == S_PARSE) begin
        if (rx_byte == CH_LF) begin
          line_cnt <= '0;
          line_err <= 1'b0;
          // o_TX_Data holds the byte in flight; tx_q1/tx_q2 hold the rest of the reply
          if (cmd_set) begin
            o_LED     <= LED_WIDTH'({hex_val(line_arg0), hex_val(line_arg1)});
            o_TX_Data <= CH_K;
            tx_q1     <= CH_LF;
            tx_left   <= 2'd1;
          end else if (cmd_read) begin
            o_TX_Data <= hex_char(led8[7:4]);
            tx_q1     <= hex_char(led8[3:0]);
            tx_q2     <= CH_LF;
            tx_left   <= 2'd2;
          end else if (!line_empty) begin
            o_Cmd_Error <= 1'b1;
            o_TX_Data   <= CH_Q;
            tx_q1       <= CH_LF;
            tx_left     <= 2'd1;
          end
        end else if (rx_byte != CH_CR && !line_err) begin
          case (line_cnt)
            2'd0:    line_cmd  <= rx_byte;
            2'd1:    line_arg0 <= rx_byte;
            2'd2:    line_arg1 <= rx_byte;
            default: line_err  <= 1'b1;
          endcase
          if (line_cnt != 2'd3) line_cnt <= line_cnt + 2'd1;
        end
      end
      if (state_q == S_TX_DONE && !i_Busy_TX && tx_left != 2'd0) begin
        o_TX_Data <= tx_q1;
        tx_q1     <= tx_q2;
        tx_left   <= tx_left - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_led_cmd.sv
// Bench for uart_led_cmd: FIFO and transmitter models plus a line-level reply model.
module tb_uart_led_cmd;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       i_Received;
  logic       o_Read_FIFO;
  logic       i_Data_Ready;
  logic [7:0] i_Data;
  logic       o_Start;
  logic [7:0] o_TX_Data;
  logic       i_Busy_TX;
  logic [7:0] o_LED;
  logic       o_Cmd_Error;

  int tests_run = 0;
  int tests_failed = 0;

  uart_led_cmd #(.LED_WIDTH(8), .LED_RESET(8'h00)) dut (
    .Clock(Clock), .Reset(Reset), .i_Received(i_Received), .o_Read_FIFO(o_Read_FIFO),
    .i_Data_Ready(i_Data_Ready), .i_Data(i_Data), .o_Start(o_Start), .o_TX_Data(o_TX_Data),
    .i_Busy_TX(i_Busy_TX), .o_LED(o_LED), .o_Cmd_Error(o_Cmd_Error)
  );

  always #5 Clock = ~Clock;

  logic [7:0] fifo[$];
  logic [7:0] tx_log[$];
  logic [7:0] exp_tx[$];
  logic [7:0] k_led[$];
  logic [7:0] cur[$];
  logic [7:0] exp_led = 8'h00;
  int         exp_err = 0;
  int         err_count = 0;
  int         start_count = 0;
  int         pop_count = 0;
  int         pop_txsize = 0;
  bit         hold_busy = 0;
  bit         start_pending = 0;
  bit         have = 0;
  bit         prev_err = 0;
  bit         prev_pop = 0;
  string      hx = "0123456789ABCDEFabcdef";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: works on whole lines, CRs stripped.
  function automatic int hexv(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  function automatic logic [7:0] hexch(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  task automatic model_line();
    if (cur.size() == 0) return;
    if (cur.size() == 3 && cur[0] == "L" && hexv(cur[1]) >= 0 && hexv(cur[2]) >= 0) begin
      exp_led = 8'(hexv(cur[1]) * 16 + hexv(cur[2]));
      k_led.push_back(exp_led);
      exp_tx.push_back(8'h4B);
      exp_tx.push_back(8'h0A);
    end else if (cur.size() == 1 && cur[0] == "R") begin
      exp_tx.push_back(hexch(int'(exp_led) / 16));
      exp_tx.push_back(hexch(int'(exp_led) % 16));
      exp_tx.push_back(8'h0A);
    end else begin
      exp_err++;
      exp_tx.push_back(8'h3F);
      exp_tx.push_back(8'h0A);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    fifo.push_back(b);
    if (b == 8'h0A) begin
      model_line();
      cur.delete();
    end else if (b != 8'h0D) cur.push_back(b);
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  function automatic logic [7:0] rhex();
    return hx[$urandom_range(0, 21)];
  endfunction

  function automatic logic [7:0] rany();
    return 8'($urandom_range(33, 126));
  endfunction

  task automatic send_random_line();
    logic [7:0] ln[$];
    int kind = int'($urandom_range(0, 6));
    case (kind)
      0, 1: begin ln.push_back("L"); ln.push_back(rhex()); ln.push_back(rhex()); end
      2:    ln.push_back("R");
      3:    begin ln.push_back("L"); ln.push_back(rany()); ln.push_back(rhex()); end
      4:    for (int i = 0; i < int'($urandom_range(0, 5)); i++) ln.push_back(rany());
      5:    begin ln.push_back("R"); ln.push_back(rhex()); end
      default: begin ln.push_back("L"); ln.push_back(rhex()); end
    endcase
    foreach (ln[i]) begin
      if ($urandom_range(0, 7) == 0) send_byte(8'h0D);
      send_byte(ln[i]);
    end
    send_byte(8'h0A);
  endtask

  // RX FIFO model: data appears 1-3 cycles after each pop
  initial begin
    logic [7:0] pb;
    int lat;
    i_Received = 0; i_Data_Ready = 0; i_Data = 8'h00;
    pb = 8'h00; lat = 0;
    forever begin
      @(posedge Clock); #1;
      i_Data_Ready = 0;
      if (Reset) have = 0;
      else begin
        if (have) begin
          if (lat == 0) begin
            i_Data_Ready = 1; i_Data = pb; have = 0;
          end else lat--;
        end
        if (o_Read_FIFO) begin
          check("pop_from_empty", 32'(fifo.size() != 0), 32'd1);
          if (fifo.size() != 0) begin
            pb = fifo.pop_front(); have = 1; lat = int'($urandom_range(0, 2));
          end
        end
      end
      i_Received = (fifo.size() != 0);
    end
  end

  // Transmitter model: busy rises the cycle after o_Start and lasts 2-6 cycles
  initial begin
    int busy_ctr = 0;
    i_Busy_TX = 0;
    forever begin
      @(posedge Clock); #1;
      if (start_pending) begin
        busy_ctr = int'($urandom_range(2, 6)); start_pending = 0;
      end else if (busy_ctr > 0) busy_ctr--;
      i_Busy_TX = hold_busy || (busy_ctr > 0);
    end
  end

  always @(negedge Clock) begin
    if (!Reset) begin
      if (o_Start) begin
        check("start_while_busy", 32'(i_Busy_TX), 32'd0);
        tx_log.push_back(o_TX_Data);
        start_pending = 1;
        start_count++;
        if (o_TX_Data == 8'h4B) begin
          check("k_reply_expected", 32'(k_led.size() != 0), 32'd1);
          if (k_led.size() != 0) check("led_before_k", 32'(o_LED), 32'(k_led.pop_front()));
        end
      end
      if (o_Cmd_Error) begin
        err_count++;
        check("err_pulse_width", 32'(prev_err), 32'd0);
      end
      if (o_Read_FIFO) begin
        check("pop_pulse_width", 32'(prev_pop), 32'd0);
        pop_count++;
        pop_txsize = tx_log.size();
      end
      prev_err = o_Cmd_Error;
      prev_pop = o_Read_FIFO;
    end
  end

  task automatic wait_quiet(input int budget);
    int quiet = 0;
    bit done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge Clock); #2;
      if (fifo.size() == 0 && !have && tx_log.size() == exp_tx.size() && !i_Busy_TX && !o_Read_FIFO)
        quiet++;
      else quiet = 0;
      if (quiet >= 8) done = 1;
    end
    check("quiet_timeout", 32'(done), 32'd1);
  endtask

  task automatic compare(input string tag);
    check({tag, "_txcount"}, 32'(tx_log.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size(); i++)
      if (i < tx_log.size()) check({tag, "_txbyte"}, 32'(tx_log[i]), 32'(exp_tx[i]));
    check({tag, "_errors"}, 32'(err_count), 32'(exp_err));
    check({tag, "_led"}, 32'(o_LED), 32'(exp_led));
    tx_log.delete();
    exp_tx.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_read_fifo"}, 32'(o_Read_FIFO), 32'd0);
    check({tag, "_start"}, 32'(o_Start), 32'd0);
    check({tag, "_tx_data"}, 32'(o_TX_Data), 32'h00);
    check({tag, "_cmd_error"}, 32'(o_Cmd_Error), 32'd0);
    check({tag, "_led"}, 32'(o_LED), 32'h00);
  endtask

  initial begin
    int pops, starts, cnt;
    Reset = 1;
    repeat (3) @(posedge Clock);
    #2;
    check_reset_outputs("por");
    Reset = 0;

    send("L5A\n");
    wait_quiet(2000); compare("set5a");
    send("R\n");
    wait_quiet(2000); compare("read5a");
    send("L0f"); send_byte(8'h0D); send("\n");
    wait_quiet(2000); compare("set0f_cr");
    send("Lg1\n");
    wait_quiet(2000); compare("badhex");
    send("L1234\n\n");
    wait_quiet(2000); compare("toolong_empty");

    // Transmitter held busy: reply waits, queued byte is not popped meanwhile
    hold_busy = 1;
    send("R\n");
    cnt = 0;
    while ((fifo.size() != 0 || have) && cnt < 500) begin @(posedge Clock); cnt++; end
    repeat (10) @(posedge Clock);
    #2;
    pops = pop_count; starts = start_count;
    send_byte("R");
    repeat (2000) @(posedge Clock);
    #2;
    check("hold_no_start", 32'(start_count), 32'(starts));
    check("hold_no_pop", 32'(pop_count), 32'(pops));
    hold_busy = 0;
    cnt = 0;
    while (pop_count == pops && cnt < 500) begin @(posedge Clock); cnt++; end
    check("pop_after_reply", 32'(pop_txsize), 32'd3);
    send("\n");
    wait_quiet(2000); compare("hold");

    // Reset after the first reply byte abandons the rest of the reply
    send("R\n");
    cnt = 0;
    while (tx_log.size() == 0 && cnt < 500) begin @(posedge Clock); cnt++; end
    check("reset_first_byte_seen", 32'(tx_log.size()), 32'd1);
    @(posedge Clock); #2;
    Reset = 1;
    #1;
    check_reset_outputs("midreply");
    while (exp_tx.size() > 1) void'(exp_tx.pop_back());
    exp_led = 8'h00;
    k_led.delete();
    repeat (3) @(posedge Clock);
    #2;
    Reset = 0;
    wait_quiet(2000); compare("reset");
    send("L33\n");
    wait_quiet(2000); compare("set33");

    for (int n = 0; n < 30; n++) begin
      int nl = int'($urandom_range(1, 3));
      for (int l = 0; l < nl; l++) send_random_line();
      wait_quiet(5000); compare("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_led_cmd.md
# uart_led_cmd

Line-oriented ASCII command parser that sits directly downstream of the UART receive FIFO and upstream of the UART transmitter. It pops received bytes one at a time, assembles a line terminated by LF (0x0A), executes LED set/read commands and sends a short ASCII reply back through the UART TX port. It replaces the raw loopback echo as the host-facing control path for the LED register.

## Interface

- LED_WIDTH, 8, width of o_LED; the L argument and R reply always carry 8 bits, zero-extended or truncated to LED_WIDTH.
- LED_RESET, 8'h00, value loaded into o_LED on reset.

- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-high; clears all state.
- i_Received  in  1  UART RX FIFO non-empty.
- o_Read_FIFO  out  1  one-cycle pop request to the FIFO.
- i_Data_Ready  in  1  i_Data valid following a pop.
- i_Data  in  8  FIFO output byte.
- o_Start  out  1  one-cycle TX start pulse.
- o_TX_Data  out  8  byte to transmit; stable from o_Start until TX busy falls.
- i_Busy_TX  in  1  transmitter busy; rises within 1 cycle of o_Start.
- o_LED  out  LED_WIDTH  LED register.
- o_Cmd_Error  out  1  one-cycle pulse when a line is rejected.

## Operation

- Grammar, uppercase command letter only:
  - "L" hh LF: set LED. h is 0-9, A-F or a-f. Reply "K" LF (0x4B 0x0A).
  - "R" LF: read LED. Reply two uppercase hex digits of o_LED[7:0], then LF.
  - CR (0x0D) is discarded anywhere. An empty line (LF alone) is ignored with no reply.
  - Any other non-empty line produces the reply "?" LF (0x3F 0x0A) and an o_Cmd_Error pulse. This covers unknown letters, bad hex digits, wrong argument count, and lines longer than 3 characters.
- Line buffer:
  - Holds the command letter and up to 2 argument characters, plus a 2-bit character count and an overflow/error flag.
  - After an error, characters are still consumed but not stored until LF.
- State machine:
  - IDLE: if i_Received is high, pulse o_Read_FIFO and go to WAIT_DATA.
  - WAIT_DATA: when i_Data_Ready is high, capture i_Data and go to PARSE.
  - PARSE (1 cycle): a non-LF byte updates the buffer and returns to IDLE. LF executes the line, loads the reply (1-3 bytes) into the TX queue, clears the buffer, and goes to TX_START; an empty line returns to IDLE.
  - TX_START: wait until i_Busy_TX is low, pulse o_Start with o_TX_Data set to the current reply byte, then go to TX_BUSY.
  - TX_BUSY: wait for i_Busy_TX to go high, then go to TX_DONE.
  - TX_DONE: wait for i_Busy_TX to go low. If more reply bytes remain, go to TX_START; otherwise go to IDLE.
- No FIFO pops occur in the TX states. RX bytes queue in the UART FIFO meanwhile.
- The LED update happens in PARSE, before the reply is sent.
- Reset, including mid-line or mid-reply: the line buffer and TX queue are cleared, state goes to IDLE, and any partially sent reply is abandoned.

## Timing

- Reset values:
  - o_Read_FIFO = 0, o_Start = 0, o_TX_Data = 0x00, o_Cmd_Error = 0.
  - o_LED = LED_RESET.
- o_Read_FIFO asserts on the cycle after IDLE sees i_Received, and stays high for exactly 1 cycle.
- PARSE occurs on the cycle after i_Data_Ready is sampled high.
- For a valid L line, o_LED updates on the clock edge ending PARSE for the LF.
- o_Cmd_Error pulses on that same edge when the line is rejected.
- The first o_Start occurs 1 cycle after PARSE if i_Busy_TX is low; otherwise on the first cycle after i_Busy_TX falls.
- Consecutive reply bytes are separated by at least 1 cycle of i_Busy_TX low.
- o_Start is never asserted while i_Busy_TX is high.

## Test plan

- After reset, stream "L5A" LF -> o_LED = 0x5A; TX sends 0x4B, 0x0A; no o_Cmd_Error pulse.
- Then stream "R" LF -> TX sends 0x35, 0x41, 0x0A; o_LED stays 0x5A.
- Stream "L0f" CR LF, then "Lg1" LF -> o_LED = 0x0F, reply "K" LF; then reply 0x3F, 0x0A with one o_Cmd_Error pulse, and o_LED stays 0x0F.
- Stream "L1234" LF, then a bare LF -> a single "?" LF reply, o_LED unchanged; the bare LF produces no TX activity.
- Hold i_Busy_TX high for 2000 cycles after "R" LF while sending a further byte into the FIFO -> no o_Start and no o_Read_FIFO until i_Busy_TX falls; then the full reply is sent, then the queued byte is popped.
- Assert Reset after the first reply byte of "R" LF -> all outputs return to their reset values immediately and the remaining bytes are not sent; a following "L33" LF gives o_LED = 0x33 and reply "K" LF.
